// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Two-port arbiter in front of a single-ported RAM. An instruction
//            fetch port (read only) and a data port (read/write) share the RAM
//            through a three-state IDLE -> ACCESS -> DONE sequence, with
//            round-robin arbitration on simultaneous requests and rejection of
//            data-port writes into the protected low address range.
// Ports    : clk        - clock, rising edge active
//            reset      - asynchronous reset, active low
//            if_req     - fetch request (level), if_addr fetch address
//            if_valid   - one-cycle pulse, if_rdata holds the fetched word
//            dm_req     - data request (level), dm_we/dm_addr/dm_wdata command
//            dm_valid   - one-cycle pulse, read data valid or write done
//            dm_err     - one-cycle pulse, protected write rejected
//            dm_rdata   - last word loaded by the data port
//            ram_addr   - RAM address, ram_rd_en / ram_wr_en RAM strobes
//            ram_data   - shared RAM data bus, driven only during writes
//            busy       - high whenever the arbiter is not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 8,
    parameter int PROT_TOP = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AWIDTH-1:0] if_addr,
    output logic              if_valid,
    output logic [DWIDTH-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [AWIDTH-1:0] dm_addr,
    input  logic [DWIDTH-1:0] dm_wdata,
    output logic              dm_valid,
    output logic              dm_err,
    output logic [DWIDTH-1:0] dm_rdata,
    output logic [AWIDTH-1:0] ram_addr,
    output logic              ram_rd_en,
    output logic              ram_wr_en,
    inout  wire  [DWIDTH-1:0] ram_data,
    output logic              busy
);

    localparam logic [AWIDTH-1:0] c_PROT_TOP = AWIDTH'(PROT_TOP);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    // Port of the current/most recent grant. It doubles as the round-robin
    // pointer: 1 means the data port was served last, so fetch wins a tie.
    logic              last_dm_q, last_dm_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              prot_q, prot_d;
    logic [DWIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DWIDTH-1:0] dm_rdata_q, dm_rdata_d;

    logic              grant_dm;

    // Data port wins if it is the only requester or if fetch was served last.
    assign grant_dm = dm_req & (~if_req | ~last_dm_q);

    always_comb begin
        state_d    = state_q;
        last_dm_d  = last_dm_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        prot_d     = prot_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    state_d = ST_ACCESS;
                    if (grant_dm) begin
                        last_dm_d = 1'b1;
                        addr_d    = dm_addr;
                        we_d      = dm_we;
                        wdata_d   = dm_wdata;
                        prot_d    = dm_we && (dm_addr < c_PROT_TOP);
                    end else begin
                        last_dm_d = 1'b0;
                        addr_d    = if_addr;
                        we_d      = 1'b0;
                        prot_d    = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                // Rejected writes keep we_q=1, so they never capture the bus.
                if (!we_q) begin
                    if (last_dm_q) begin
                        dm_rdata_d = ram_data;
                    end else begin
                        if_rdata_d = ram_data;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            last_dm_q  <= 1'b1;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            prot_q     <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_dm_q  <= last_dm_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            prot_q     <= prot_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // All outputs decode from registered state only, so an asynchronous reset
    // removes strobes and pulses immediately.
    assign busy      = (state_q != ST_IDLE);
    assign ram_addr  = addr_q;
    assign ram_rd_en = (state_q == ST_ACCESS) && !we_q;
    assign ram_wr_en = (state_q == ST_ACCESS) && we_q && !prot_q;
    assign if_valid  = (state_q == ST_DONE) && !last_dm_q;
    assign dm_valid  = (state_q == ST_DONE) && last_dm_q && !prot_q;
    assign dm_err    = (state_q == ST_DONE) && last_dm_q && prot_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    assign ram_data  = ram_wr_en ? wdata_q : {DWIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter with a behavioural RAM on the
//            shared bus, a vector table of single transactions, hand-written
//            tie and reset-abort sequences, and a scoreboard of pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int c_PROT_TOP = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [7:0]  if_addr, dm_addr;
    logic [31:0] dm_wdata;
    logic        if_valid, dm_valid, dm_err;
    logic [31:0] if_rdata, dm_rdata;
    logic [7:0]  ram_addr;
    logic        ram_rd_en, ram_wr_en, busy;
    wire  [31:0] ram_data;

    int total = 0;
    int bad   = 0;

    ram_arbiter #(.DWIDTH(32), .AWIDTH(8), .PROT_TOP(c_PROT_TOP)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_valid (dm_valid),
        .dm_err   (dm_err),
        .dm_rdata (dm_rdata),
        .ram_addr (ram_addr),
        .ram_rd_en(ram_rd_en),
        .ram_wr_en(ram_wr_en),
        .ram_data (ram_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return (i == 2) ? 32'h8061_1000 : (32'h5A00_0000 | 32'(i));
    endfunction

    // Behavioural RAM: loads its pattern on the first edge, then writes on
    // ram_wr_en and drives the bus during reads.
    bit          mem_ready = 1'b0;
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
            mem_ready <= 1'b1;
        end else if (ram_wr_en) begin
            mem[ram_addr] <= ram_data;
        end
    end
    assign ram_data = ram_rd_en ? mem[ram_addr] : 32'hzzzz_zzzz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input string info);
        total++;
        bad++;
        $display("FAIL %s: %s at %0t", name, info, $time);
    endtask

    // Scoreboard of expected completion pulses, in grant order.
    typedef struct {
        bit          dm;
        bit          err;
        logic [31:0] rdata;
    } sb_t;
    sb_t sbq[$];

    task automatic push_exp(input bit dm, input bit err, input logic [31:0] rdata);
        sb_t e;
        e.dm = dm; e.err = err; e.rdata = rdata;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        int npulse;
        sb_t e;
        npulse = int'(if_valid) + int'(dm_valid) + int'(dm_err);
        chk("rdwr_exclusive", {31'b0, ram_rd_en & ram_wr_en}, 32'd0);
        if (npulse > 1) fail("one_pulse", "more than one completion pulse");
        if (npulse != 0) begin
            if (sbq.size() == 0) begin
                fail("sb_unexpected", "completion pulse with nothing outstanding");
            end else begin
                e = sbq.pop_front();
                chk("sb_port", {31'b0, dm_valid | dm_err}, {31'b0, e.dm});
                chk("sb_err", {31'b0, dm_err}, {31'b0, e.err});
                chk("sb_rdata", e.dm ? dm_rdata : if_rdata, e.rdata);
            end
        end
    end

    // Drive one request until its completion pulse (bounded). Returns at the
    // negedge that showed the pulse, with the request already dropped.
    task automatic txn(input bit dm, input bit we, input logic [7:0] addr,
                       input logic [31:0] wd, input int exp_lat, input bit chk_en);
        int n  = 0;
        int rd = 0;
        int wr = 0;
        bit done = 1'b0;
        if (dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (chk_en) begin
                chk("busy_active", {31'b0, busy}, 32'd1);
                if (ram_rd_en) begin
                    rd++;
                    chk("rd_addr", {24'b0, ram_addr}, {24'b0, addr});
                end
                if (ram_wr_en) begin
                    wr++;
                    chk("wr_addr", {24'b0, ram_addr}, {24'b0, addr});
                    chk("wr_data", ram_data, wd);
                end
            end
            if (dm ? (dm_valid | dm_err) : if_valid) done = 1'b1;
        end
        if (dm) begin
            dm_req = 1'b0; dm_we = 1'b0;
        end else begin
            if_req = 1'b0;
        end
        if (!done) begin
            fail("timeout", dm ? "data port got no pulse" : "fetch port got no pulse");
        end else begin
            if (exp_lat != 0) chk("latency", n, exp_lat);
            if (chk_en) begin
                chk("rd_cycles", rd, (!dm || !we) ? 1 : 0);
                chk("wr_cycles", wr, (dm && we && int'(addr) >= c_PROT_TOP) ? 1 : 0);
            end
        end
    endtask

    typedef struct {
        bit          dm;
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;  // expected if_rdata (fetch) or dm_rdata (data)
    } vec_t;
    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 8'h02, 32'h0000_0000, 1'b0, 32'h8061_1000};
        vecs[1]  = '{1'b1, 1'b1, 8'h80, 32'hDEAD_BEEF, 1'b0, 32'h5A00_0010};
        vecs[2]  = '{1'b1, 1'b0, 8'h80, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 1'b1, 8'h03, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 1'b0, 8'h03, 32'h0000_0000, 1'b0, 32'h5A00_0003};
        vecs[5]  = '{1'b1, 1'b1, 8'h06, 32'h0BAD_F00D, 1'b0, 32'h5A00_0003};
        vecs[6]  = '{1'b1, 1'b0, 8'h06, 32'h0000_0000, 1'b0, 32'h0BAD_F00D};
        vecs[7]  = '{1'b0, 1'b0, 8'h80, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 1'b1, 8'h05, 32'h7777_7777, 1'b1, 32'h0BAD_F00D};
        vecs[9]  = '{1'b0, 1'b0, 8'h05, 32'h0000_0000, 1'b0, 32'h5A00_0005};
        vecs[10] = '{1'b1, 1'b1, 8'hFF, 32'hCAFE_F00D, 1'b0, 32'h0BAD_F00D};
        vecs[11] = '{1'b0, 1'b0, 8'hFF, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};

        reset = 1'b0;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy",     {31'b0, busy},      32'd0);
        chk("rst_if_valid", {31'b0, if_valid},  32'd0);
        chk("rst_dm_valid", {31'b0, dm_valid},  32'd0);
        chk("rst_dm_err",   {31'b0, dm_err},    32'd0);
        chk("rst_rd_en",    {31'b0, ram_rd_en}, 32'd0);
        chk("rst_wr_en",    {31'b0, ram_wr_en}, 32'd0);
        chk("rst_ram_addr", {24'b0, ram_addr},  32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Tie straight after reset: fetch first; fetch re-requests at once,
        // so the second tie goes to the data port, then fetch again.
        push_exp(1'b0, 1'b0, 32'h8061_1000);
        push_exp(1'b1, 1'b0, 32'h5A00_0010);
        push_exp(1'b0, 1'b0, 32'h5A00_0004);
        fork
            begin
                txn(1'b0, 1'b0, 8'h02, 32'h0, 2, 1'b0);
                @(negedge clk);
                txn(1'b0, 1'b0, 8'h04, 32'h0, 5, 1'b0);
            end
            begin
                txn(1'b1, 1'b0, 8'h10, 32'h0, 5, 1'b0);
            end
        join
        @(negedge clk);
        chk("tie_idle_busy", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            push_exp(vecs[i].dm, vecs[i].err, vecs[i].rdata);
            txn(vecs[i].dm, vecs[i].we, vecs[i].addr, vecs[i].wdata, 2, 1'b1);
            @(negedge clk);
            chk("idle_busy", {31'b0, busy}, 32'd0);
        end
        chk("prot_mem3", mem[3], 32'h5A00_0003);
        chk("prot_mem5", mem[5], 32'h5A00_0005);
        chk("mem_80",    mem[8'h80], 32'hDEAD_BEEF);

        // Reset asserted in the middle of a write access.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h40; dm_wdata = 32'h1111_2222;
        @(negedge clk);
        chk("mw_wr_en_before", {31'b0, ram_wr_en}, 32'd1);
        chk("mw_data_before",  ram_data, 32'h1111_2222);
        #2 reset = 1'b0;
        #1;
        chk("mw_wr_en",    {31'b0, ram_wr_en}, 32'd0);
        chk("mw_rd_en",    {31'b0, ram_rd_en}, 32'd0);
        chk("mw_busy",     {31'b0, busy},      32'd0);
        chk("mw_dm_valid", {31'b0, dm_valid},  32'd0);
        chk("mw_dm_rdata", dm_rdata, 32'd0);
        dm_req = 1'b0; dm_we = 1'b0;
        repeat (2) @(negedge clk);
        chk("mw_mem_kept", mem[8'h40], 32'h5A00_0040);
        reset = 1'b1;
        @(negedge clk);
        chk("mw_post_busy", {31'b0, busy}, 32'd0);

        push_exp(1'b0, 1'b0, 32'h8061_1000);
        txn(1'b0, 1'b0, 8'h02, 32'h0, 2, 1'b1);
        repeat (2) @(negedge clk);

        chk("sb_drained", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
